eq_compare_monitor: RTL



---
 rtl/eq_compare_monitor.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/eq_compare_monitor.sv
// -----------------------------------------------------------------------------
// eq_compare_monitor
//
// Result monitor for the 16-bit equality-comparator cross-check. It sits
// downstream of two comparator implementations (A and B) and also sees the
// operand pair that produced their results. On every accepted sample it:
//   - computes a local golden result g = (a == b),
//   - flags a failure when A and B disagree, or when B disagrees with golden,
//   - counts checked and failing samples with saturating counters,
//   - captures operands, results and cause of the first failing sample,
//   - optionally halts checking after the first failure (STOP_ON_ERR).
//
// Parameters
//   WIDTH       operand width
//   CNT_W       width of the checked/mismatch counters
//   WARMUP      clock cycles after reset release during which samples are
//               ignored (0 = leave warmup on the first edge)
//   STOP_ON_ERR 1 = stop checking (HALT) on the first failure
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   valid_i      sample strobe
//   a_i, b_i     operand pair
//   res_a_i      result of implementation A
//   res_b_i      result of implementation B
//   clear_i      synchronous clear of counters, sticky flag and captures
//   ready_o      high while in RUN
//   checked_o    number of checked samples (saturating)
//   mism_o       number of failing samples (saturating)
//   err_pulse_o  one-cycle pulse in the cycle after a failing sample
//   err_o        sticky error flag
//   cause_o      cause of first failure: bit0 = A!=B, bit1 = B!=golden
//   first_a_o    operand a of first failing sample
//   first_b_o    operand b of first failing sample
//   first_res_o  {res_a, res_b} of first failing sample
// -----------------------------------------------------------------------------
module eq_compare_monitor #(
  parameter int WIDTH       = 16,
  parameter int CNT_W       = 16,
  parameter int WARMUP      = 2,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             res_a_i,
  input  logic             res_b_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic [CNT_W-1:0] checked_o,
  output logic [CNT_W-1:0] mism_o,
  output logic             err_pulse_o,
  output logic             err_o,
  output logic [1:0]       cause_o,
  output logic [WIDTH-1:0] first_a_o,
  output logic [WIDTH-1:0] first_b_o,
  output logic [1:0]       first_res_o
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  // Warmup counter only needs to hold WARMUP itself.
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WCW-1:0] WARM_INIT = WCW'(WARMUP);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam bit HALT_EN = (STOP_ON_ERR != 0);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]       state_reg,     state_next;
  logic [WCW-1:0]   warm_cnt_reg,  warm_cnt_next;
  logic [CNT_W-1:0] checked_reg,   checked_next;
  logic [CNT_W-1:0] mism_reg,      mism_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             err_reg,       err_next;
  logic [1:0]       cause_reg,     cause_next;
  logic [WIDTH-1:0] first_a_reg,   first_a_next;
  logic [WIDTH-1:0] first_b_reg,   first_b_next;
  logic [1:0]       first_res_reg, first_res_next;

  // ---------------------------------------------------------------------------
  // Golden result: per-bit equality, then AND-reduce across the full width.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] bit_eq;
  logic             golden;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_eq
      assign bit_eq[gi] = ~(a_i[gi] ^ b_i[gi]);
    end
  endgenerate

  assign golden = &bit_eq;

  // Failure classification for the current sample.
  logic fail_ab;
  logic fail_gold;
  logic fail_any;

  assign fail_ab   = res_a_i != res_b_i;
  assign fail_gold = res_b_i != golden;
  assign fail_any  = fail_ab | fail_gold;

  // A sample is checked only in RUN, and a simultaneous clear discards it.
  logic sample_take;
  assign sample_take = valid_i && !clear_i && (state_reg == ST_RUN);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    warm_cnt_next  = warm_cnt_reg;
    checked_next   = checked_reg;
    mism_next      = mism_reg;
    err_pulse_next = 1'b0;
    err_next       = err_reg;
    cause_next     = cause_reg;
    first_a_next   = first_a_reg;
    first_b_next   = first_b_reg;
    first_res_next = first_res_reg;

    // Sequencing. Leaving warmup when the counter is about to hit zero makes
    // exactly WARMUP edges drop their samples; clear never touches warmup.
    case (state_reg)
      ST_WARMUP: begin
        if (warm_cnt_reg <= WARM_LAST) begin
          state_next    = ST_RUN;
          warm_cnt_next = '0;
        end else begin
          warm_cnt_next = warm_cnt_reg - WARM_LAST;
        end
      end
      ST_RUN: begin
        if (HALT_EN && sample_take && fail_any) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (clear_i) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_WARMUP;
      end
    endcase

    // Checking datapath.
    if (clear_i) begin
      checked_next   = '0;
      mism_next      = '0;
      err_next       = 1'b0;
      cause_next     = 2'b00;
      first_a_next   = '0;
      first_b_next   = '0;
      first_res_next = 2'b00;
    end else if (sample_take) begin
      if (checked_reg != CNT_MAX) begin
        checked_next = checked_reg + CNT_ONE;
      end
      if (fail_any) begin
        if (mism_reg != CNT_MAX) begin
          mism_next = mism_reg + CNT_ONE;
        end
        err_pulse_next = 1'b1;
        err_next       = 1'b1;
        // Only the first failure since reset/clear is captured.
        if (!err_reg) begin
          cause_next     = {fail_gold, fail_ab};
          first_a_next   = a_i;
          first_b_next   = b_i;
          first_res_next = {res_a_i, res_b_i};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_WARMUP;
      warm_cnt_reg  <= WARM_INIT;
      checked_reg   <= '0;
      mism_reg      <= '0;
      err_pulse_reg <= 1'b0;
      err_reg       <= 1'b0;
      cause_reg     <= 2'b00;
      first_a_reg   <= '0;
      first_b_reg   <= '0;
      first_res_reg <= 2'b00;
    end else begin
      state_reg     <= state_next;
      warm_cnt_reg  <= warm_cnt_next;
      checked_reg   <= checked_next;
      mism_reg      <= mism_next;
      err_pulse_reg <= err_pulse_next;
      err_reg       <= err_next;
      cause_reg     <= cause_next;
      first_a_reg   <= first_a_next;
      first_b_reg   <= first_b_next;
      first_res_reg <= first_res_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------------
  assign ready_o     = (state_reg == ST_RUN);
  assign checked_o   = checked_reg;
  assign mism_o      = mism_reg;
  assign err_pulse_o = err_pulse_reg;
  assign err_o       = err_reg;
  assign cause_o     = cause_reg;
  assign first_a_o   = first_a_reg;
  assign first_b_o   = first_b_reg;
  assign first_res_o = first_res_reg;

endmodule
